// File: rtl/data_ram.sv
// True dual-port 2^ADDR_BITS x 32-bit RAM with per-byte write enables.
// Both ports are read-first; port A wins when both write the same byte.
module data_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wea,
    input  logic [29:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    input  logic [3:0]  web,
    input  logic [29:0] addrb,
    input  logic [31:0] dinb,
    output logic [31:0] doutb
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // NOTE: declaration initialisers give zero contents and zero outputs at
    // power-up (FPGA bitstream init); the array is never reset, so it stays
    // inferable as block RAM and keeps its data across rst.
    logic [31:0] r_mem [DEPTH] = '{default: 32'h0000_0000};
    logic [31:0] r_douta = 32'h0000_0000;
    logic [31:0] r_doutb = 32'h0000_0000;

    logic [ADDR_BITS-1:0] w_idxa;
    logic [ADDR_BITS-1:0] w_idxb;
    logic                 w_unused_addr;

    // Upper word-address bits are ignored, so addresses alias modulo depth.
    assign w_idxa        = addra[ADDR_BITS-1:0];
    assign w_idxb        = addrb[ADDR_BITS-1:0];
    assign w_unused_addr = ^{addra[29:ADDR_BITS], addrb[29:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_douta <= 32'h0000_0000;
            r_doutb <= 32'h0000_0000;
        end else begin
            // NOTE: non-blocking reads here sample the pre-edge contents, which
            // is what makes both ports read-first, including across ports.
            r_douta <= r_mem[w_idxa];
            r_doutb <= r_mem[w_idxb];
            // Port A is assigned last so it overrides port B on a shared byte.
            for (int i = 0; i < 4; i++) begin
                if (web[i]) begin
                    r_mem[w_idxb][8*i +: 8] <= dinb[8*i +: 8];
                end
                if (wea[i]) begin
                    r_mem[w_idxa][8*i +: 8] <= dina[8*i +: 8];
                end
            end
        end
    end

    assign douta = r_douta;
    assign doutb = r_doutb;

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram (ADDR_BITS = 12).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_data_ram;

    logic        clk;
    logic        rst;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [3:0]  web;
    logic [29:0] addrb;
    logic [31:0] dinb;
    logic [31:0] doutb;

    int n_total = 0;
    int n_bad   = 0;

    data_ram #(.ADDR_BITS(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] we, input logic [29:0] addr, input logic [31:0] din);
        wea   = we;
        addra = addr;
        dina  = din;
    endtask

    task automatic set_b(input logic [3:0] we, input logic [29:0] addr, input logic [31:0] din);
        web   = we;
        addrb = addr;
        dinb  = din;
    endtask

    initial begin
        rst = 1'b1;
        set_a(4'h0, 30'd0, 32'h0);
        set_b(4'h0, 30'd0, 32'h0);
        #1;
        check("pre_edge_douta", douta, 32'h0000_0000);
        check("pre_edge_doutb", doutb, 32'h0000_0000);

        tick();
        check("reset_douta", douta, 32'h0000_0000);
        check("reset_doutb", doutb, 32'h0000_0000);

        // Power-up contents are zero.
        rst = 1'b0;
        set_a(4'h0, 30'd100, 32'hFFFF_FFFF);
        set_b(4'h0, 30'd200, 32'hFFFF_FFFF);
        tick();
        check("powerup_a", douta, 32'h0000_0000);
        check("powerup_b", doutb, 32'h0000_0000);

        // Full-word write on port A, then read from both ports.
        set_a(4'hF, 30'd5, 32'hDEAD_BEEF);
        tick();
        check("write5_readfirst", douta, 32'h0000_0000);
        set_a(4'h0, 30'd5, 32'h0);
        set_b(4'h0, 30'd5, 32'h0);
        tick();
        check("read5_a", douta, 32'hDEAD_BEEF);
        check("read5_b", doutb, 32'hDEAD_BEEF);

        // Reset clears outputs, suppresses writes, keeps contents.
        set_a(4'hF, 30'd5, 32'h0);
        set_b(4'hF, 30'd5, 32'h0);
        rst = 1'b1;
        tick();
        check("rst_douta", douta, 32'h0000_0000);
        check("rst_doutb", doutb, 32'h0000_0000);
        rst = 1'b0;
        set_a(4'h0, 30'd5, 32'h0);
        set_b(4'h0, 30'd5, 32'h0);
        tick();
        check("post_rst_a", douta, 32'hDEAD_BEEF);
        check("post_rst_b", doutb, 32'hDEAD_BEEF);

        // Single-byte write on byte 2.
        set_a(4'b0100, 30'd5, 32'h00AA_0000);
        tick();
        check("bytewr_readfirst", douta, 32'hDEAD_BEEF);
        set_a(4'h0, 30'd5, 32'h0);
        tick();
        check("bytewr_result", douta, 32'hDEAA_BEEF);

        // Read-first on the same port and across ports.
        set_a(4'h0, 30'd0, 32'h0);
        set_b(4'hF, 30'd7, 32'h1111_1111);
        tick();
        set_a(4'hF, 30'd7, 32'h2222_2222);
        set_b(4'h0, 30'd7, 32'h0);
        tick();
        check("rf_same_port", douta, 32'h1111_1111);
        check("rf_cross_port", doutb, 32'h1111_1111);
        set_a(4'h0, 30'd7, 32'h0);
        tick();
        check("rf_after_a", douta, 32'h2222_2222);
        check("rf_after_b", doutb, 32'h2222_2222);

        // Collision: port A wins on shared bytes.
        set_a(4'hF, 30'd9, 32'hAAAA_AAAA);
        set_b(4'h3, 30'd9, 32'h5555_5555);
        tick();
        set_a(4'h0, 30'd9, 32'hFFFF_FFFF);
        set_b(4'h0, 30'd9, 32'hFFFF_FFFF);
        tick();
        tick();
        check("collide_a", douta, 32'hAAAA_AAAA);
        check("collide_b", doutb, 32'hAAAA_AAAA);

        // Partial overlap: byte3 A only, byte2 both, byte1 B only, byte0 none.
        set_a(4'b1100, 30'd10, 32'hAAAA_AAAA);
        set_b(4'b0110, 30'd10, 32'h5555_5555);
        tick();
        set_a(4'h0, 30'd10, 32'h0);
        set_b(4'h0, 30'd10, 32'h0);
        tick();
        check("mixed_bytes", douta, 32'hAAAA_5500);

        // Aliasing: upper address bits are ignored.
        set_a(4'hF, 30'h1003, 32'h1234_5678);
        tick();
        set_a(4'h0, 30'h3FFF_F003, 32'h0);
        set_b(4'h0, 30'd3, 32'h0);
        tick();
        check("alias_b", doutb, 32'h1234_5678);
        check("alias_a_high", douta, 32'h1234_5678);

        // Word 5 untouched by the other writes.
        set_a(4'h0, 30'h0000_1005, 32'h0);
        tick();
        check("word5_final", douta, 32'hDEAA_BEEF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter ADDR_BITS, default 12, meaning: number of low word-address bits used to index the array; depth = 2^ADDR_BITS 32-bit words.
REQ-002 clk  input  1  single clock; all reads, writes and reset act on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 wea  input  4  port A byte write enables; bit i writes byte i, bits [8i+7:8i].
REQ-005 addra  input  30  port A word address, i.e. byte address [31:2].
REQ-006 dina  input  32  port A write data.
REQ-007 douta  output  32  port A registered read data.
REQ-008 web  input  4  port B (debug) byte write enables, same bit mapping as wea.
REQ-009 addrb  input  30  port B word address.
REQ-010 dinb  input  32  port B write data.
REQ-011 doutb  output  32  port B registered read data.

Function
REQ-012 The block SHALL be a true dual-port RAM of 2^ADDR_BITS x 32-bit words, both ports fully independent and synchronous to clk.
REQ-013 Each port SHALL index the array with addr[ADDR_BITS-1:0]; upper address bits SHALL be ignored, so addresses alias modulo depth.
REQ-014 On a rising edge with rst=0, each port SHALL write every byte whose enable bit is 1 from the matching din byte; bytes with enable 0 SHALL keep their value.
REQ-015 On every rising edge with rst=0, each port SHALL register the word at its address into dout; read latency SHALL be exactly one cycle.
REQ-016 Same-port read-during-write SHALL be read-first: dout shows the word contents from before that edge's write.
REQ-017 Cross-port read of a word being written in the same edge SHALL also return the pre-write contents.
REQ-018 When both ports write the same byte of the same word in the same edge, port A SHALL win; bytes enabled on only one port SHALL take that port's data.
REQ-019 wea/web of 4'b0000 SHALL be a pure read; dout still updates.
REQ-020 Byte steering (shifting data and enables for sub-word stores) SHALL be the caller's responsibility; the RAM applies wea/dina as given.
REQ-021 Array contents SHALL be zero at power-up (initial state, simulation and FPGA bitstream).
REQ-022 The array SHALL be inferable as block RAM (no asynchronous read paths).

Reset
REQ-023 On a rising edge with rst=1, douta and doutb SHALL become 32'h0000_0000.
REQ-024 While rst=1, writes on both ports SHALL be suppressed.
REQ-025 rst SHALL NOT clear array contents; data written before reset SHALL be readable after rst deasserts.
REQ-026 Before the first clock edge, douta and doutb SHALL be 0.
REQ-027 The first edge with rst=0 after reset SHALL perform a normal read/write.

Verification
REQ-028 Port A: wea=4'hF, addra=5, dina=32'hDEADBEEF; next edge wea=0, addra=5 -> douta=32'hDEADBEEF one cycle later; doutb at addrb=5 also 32'hDEADBEEF.
REQ-029 Byte write: word 5 = 32'hDEADBEEF, wea=4'b0100, dina=32'h00AA0000 -> subsequent read of word 5 gives 32'hDEAABEEF.
REQ-030 Read-first: word 7 = 32'h11111111, same edge wea=4'hF, dina=32'h22222222, addra=7 -> douta=32'h11111111; next read -> 32'h22222222.
REQ-031 Collision: same edge wea=4'hF dina=32'hAAAAAAAA and web=4'h3 dinb=32'h55555555 at address 9 -> word 9 = 32'hAAAAAAAA.
REQ-032 Aliasing: write 32'h12345678 at addra=30'h1003 (ADDR_BITS=12) -> read at addrb=3 gives 32'h12345678.
REQ-033 Reset: douta nonzero, assert rst one cycle with wea=4'hF dina=0 at addra=5 -> douta=doutb=0; after release read word 5 -> 32'hDEADBEEF unchanged.
